// File: rtl/clock_time_ctrl_if.sv
// Button inputs and display/status outputs of the clock controller; alarm fields exist only with CLK_ALARM_EN.
// slave = controller side, master = button/display side.
interface clock_time_ctrl_if;
    logic       btnMode;
    logic       btnInc;
    logic [5:0] secOut;
    logic [5:0] minOut;
    logic [4:0] hourOut;
    logic [2:0] modeOut;
    logic       tickSec;
    logic       ovflwDay;
`ifdef CLK_ALARM_EN
    logic [4:0] almHourOut;
    logic [5:0] almMinOut;
    logic       almHit;
`endif

    modport slave (
        input  btnMode, btnInc,
        output secOut, minOut, hourOut, modeOut, tickSec, ovflwDay
`ifdef CLK_ALARM_EN
        , output almHourOut, almMinOut, almHit
`endif
    );

    modport master (
        output btnMode, btnInc,
        input  secOut, minOut, hourOut, modeOut, tickSec, ovflwDay
`ifdef CLK_ALARM_EN
        , input almHourOut, almMinOut, almHit
`endif
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// hh:mm:ss timekeeper with 1 Hz prescaler and button set-mode FSM; alarm states/registers with CLK_ALARM_EN.
// All outputs registered; a button pulse acts on the edge that samples it; no backpressure, pulses never stall.
module clock_time_ctrl #(
    parameter int CLK_HZ = 50000000
) (
    input  logic               clk,
    input  logic               resetN,
    clock_time_ctrl_if.slave   bus
);
    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    localparam logic [2:0] RUN       = 3'd0;
    localparam logic [2:0] SET_HOUR  = 3'd1;
    localparam logic [2:0] SET_MIN   = 3'd2;
    localparam logic [2:0] SET_ALM_H = 3'd3;
    localparam logic [2:0] SET_ALM_M = 3'd4;

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [2:0]    mode_q, mode_d;
    logic          tick_q, tick_d, ovf_q, ovf_d;
    logic          counting, adv;
`ifdef CLK_ALARM_EN
    logic [4:0]    ah_q, ah_d;
    logic [5:0]    am_q, am_d;
    logic          hit_q, hit_d;

    assign counting = (mode_q == RUN) || (mode_q == SET_ALM_H) || (mode_q == SET_ALM_M);
`else
    assign counting = (mode_q == RUN);
`endif
    assign adv = counting && (pre_q == PRE_MAX);

    always_comb begin
        pre_d  = counting ? (adv ? '0 : pre_q + PW'(1)) : '0;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        mode_d = mode_q;
        tick_d = adv;
        ovf_d  = 1'b0;
`ifdef CLK_ALARM_EN
        ah_d   = ah_q;
        am_d   = am_q;
        hit_d  = 1'b0;
`endif
        // Whole carry chain settles in this one evaluation.
        if (adv) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    if (hour_q == 5'd23) begin
                        hour_d = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
`ifdef CLK_ALARM_EN
        hit_d = adv && (mode_q == RUN) && (sec_d == '0) && (min_d == am_q) && (hour_d == ah_q);
`endif
        if (bus.btnMode) begin
            case (mode_q)
                RUN:      mode_d = SET_HOUR;
                SET_HOUR: mode_d = SET_MIN;
                SET_MIN: begin
`ifdef CLK_ALARM_EN
                    mode_d = SET_ALM_H;
`else
                    mode_d = RUN;
`endif
                    sec_d = '0;
                    pre_d = '0;
                end
`ifdef CLK_ALARM_EN
                SET_ALM_H: mode_d = SET_ALM_M;
`endif
                default:  mode_d = RUN;
            endcase
        end else if (bus.btnInc) begin
            case (mode_q)
                SET_HOUR:  hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                SET_MIN:   min_d  = (min_q == 6'd59) ? '0 : min_q + 6'd1;
`ifdef CLK_ALARM_EN
                SET_ALM_H: ah_d   = (ah_q == 5'd23) ? '0 : ah_q + 5'd1;
                SET_ALM_M: am_d   = (am_q == 6'd59) ? '0 : am_q + 6'd1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pre_q  <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            mode_q <= RUN;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef CLK_ALARM_EN
            ah_q   <= '0;
            am_q   <= '0;
            hit_q  <= 1'b0;
`endif
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            ovf_q  <= ovf_d;
`ifdef CLK_ALARM_EN
            ah_q   <= ah_d;
            am_q   <= am_d;
            hit_q  <= hit_d;
`endif
        end
    end

    assign bus.secOut   = sec_q;
    assign bus.minOut   = min_q;
    assign bus.hourOut  = hour_q;
    assign bus.modeOut  = mode_q;
    assign bus.tickSec  = tick_q;
    assign bus.ovflwDay = ovf_q;
`ifdef CLK_ALARM_EN
    assign bus.almHourOut = ah_q;
    assign bus.almMinOut  = am_q;
    assign bus.almHit     = hit_q;
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: time-of-day reference model feeding a per-cycle scoreboard, plus directed checks.
`timescale 1ns/1ps
module tb_clock_time_ctrl;
    localparam int HZ  = 4;
    localparam int DAY = 86400;

    logic clk    = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    clock_time_ctrl_if bus();
    clock_time_ctrl #(.CLK_HZ(HZ)) dut (.clk(clk), .resetN(resetN), .bus(bus));

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [2:0] mode;
        logic       tick;
        logic       ovf;
        logic [4:0] ah;
        logic [5:0] am;
        logic       hit;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: time as seconds-of-day, mode as a position in the mode cycle.
    int mode_seq[$];
    int tod, pre, mode_idx, ah, am;
    bit m_tick, m_ovf, m_hit;

    function automatic obs_t model_obs();
        obs_t o;
        o.sec  = 6'(tod % 60);
        o.min  = 6'((tod / 60) % 60);
        o.hour = 5'(tod / 3600);
        o.mode = 3'(mode_seq[mode_idx]);
        o.tick = m_tick;
        o.ovf  = m_ovf;
        o.ah   = 5'(ah);
        o.am   = 6'(am);
        o.hit  = m_hit;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.sec  = bus.secOut;
        o.min  = bus.minOut;
        o.hour = bus.hourOut;
        o.mode = bus.modeOut;
        o.tick = bus.tickSec;
        o.ovf  = bus.ovflwDay;
`ifdef CLK_ALARM_EN
        o.ah   = bus.almHourOut;
        o.am   = bus.almMinOut;
        o.hit  = bus.almHit;
`else
        o.ah   = '0;
        o.am   = '0;
        o.hit  = 1'b0;
`endif
        return o;
    endfunction

    task automatic model_step(input bit bm, input bit bi);
        int m, h, mi, s;
        m = mode_seq[mode_idx];
        m_tick = 0; m_ovf = 0; m_hit = 0;
        if (m == 0 || m == 3 || m == 4) begin
            if (pre == HZ - 1) begin
                pre    = 0;
                tod    = (tod + 1) % DAY;
                m_tick = 1;
                m_ovf  = (tod == 0);
`ifdef CLK_ALARM_EN
                m_hit  = (m == 0) && (tod == ah * 3600 + am * 60);
`endif
            end else begin
                pre = pre + 1;
            end
        end else begin
            pre = 0;
        end
        h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
        if (bm) begin
            if (m == 2) begin
                tod = tod - s;
                pre = 0;
            end
            mode_idx = (mode_idx + 1) % mode_seq.size();
        end else if (bi) begin
            case (m)
                1: tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
                2: tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
                3: ah  = (ah + 1) % 24;
                4: am  = (am + 1) % 60;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every clock edge the DUT presents a new output word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = dut_obs();
                n_tests++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard at %0t: got %h, want %h", $time, mon_a, mon_e);
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 of the next cycle.
    task automatic cyc(input bit bm, input bit bi);
        @(negedge clk);
        bus.btnMode = bm;
        bus.btnInc  = bi;
        model_step(bm, bi);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        #1;
        resetN      = 1'b0;
        bus.btnMode = 1'b0;
        bus.btnInc  = 1'b0;
        tod = 0; pre = 0; mode_idx = 0; ah = 0; am = 0;
        m_tick = 0; m_ovf = 0; m_hit = 0;
        #1;
        chk("rst_sec",  bus.secOut,   0);
        chk("rst_min",  bus.minOut,   0);
        chk("rst_hour", bus.hourOut,  0);
        chk("rst_mode", bus.modeOut,  0);
        chk("rst_tick", bus.tickSec,  0);
        chk("rst_ovf",  bus.ovflwDay, 0);
`ifdef CLK_ALARM_EN
        chk("rst_alm", {bus.almHourOut, bus.almMinOut, bus.almHit}, 0);
`endif
        @(posedge clk);
        #3 resetN = 1'b1;
    endtask

    int ticks, ovfs, coinc, hits, s0, m0;

    initial begin
`ifdef CLK_ALARM_EN
        mode_seq = '{0, 1, 2, 3, 4};
`else
        mode_seq = '{0, 1, 2};
`endif
        bus.btnMode = 1'b0;
        bus.btnInc  = 1'b0;
        #2;
        async_reset();

        // Free run: first tick on cycle 4, 60 ticks give 00:01:00.
        ticks = 0;
        for (int k = 1; k <= 240; k++) begin
            cyc(0, 0);
            if (k <= 4) chk("first_tick", bus.tickSec, (k == 4) ? 1 : 0);
            ticks += bus.tickSec;
        end
        chk("free_ticks", ticks, 60);
        chk("free_sec", bus.secOut, 0);
        chk("free_min", bus.minOut, 1);
        chk("free_hour", bus.hourOut, 0);

        repeat (10) cyc(0, 0);
        async_reset();

        // Day wrap from 23:59:00.
        cyc(1, 0);
        repeat (23) cyc(0, 1);
        chk("set_hour23", bus.hourOut, 23);
        cyc(1, 0);
        repeat (59) cyc(0, 1);
        chk("set_min59", bus.minOut, 59);
        cyc(1, 0);
        chk("back_mode", bus.modeOut, mode_seq[mode_idx]);
        chk("back_sec", bus.secOut, 0);
        ovfs = 0; coinc = 0;
        for (int k = 0; k < 244; k++) begin
            cyc(0, 0);
            ovfs += bus.ovflwDay;
            if (bus.ovflwDay && bus.tickSec && bus.secOut == 0 && bus.minOut == 0 && bus.hourOut == 0)
                coinc++;
        end
`ifndef CLK_ALARM_EN
        chk("wrap_ovf_count", ovfs, 1);
        chk("wrap_coincident", coinc, 1);
`endif
        if (mode_seq[mode_idx] != 0) begin
            cyc(1, 0);
            cyc(1, 0);
        end

        // Set-mode hour wrap, then mode/inc collision.
        cyc(1, 0);
        while (tod / 3600 != 23) cyc(0, 1);
        s0 = bus.secOut; m0 = bus.minOut;
        cyc(0, 1);
        chk("setwrap_hour", bus.hourOut, 0);
        chk("setwrap_min", bus.minOut, m0);
        chk("setwrap_sec", bus.secOut, s0);
        chk("setwrap_ovf", bus.ovflwDay, 0);
        repeat (5) cyc(0, 1);
        chk("coll_pre_hour", bus.hourOut, 5);
        cyc(1, 1);
        chk("coll_mode", bus.modeOut, 2);
        chk("coll_hour", bus.hourOut, 5);
        cyc(1, 0);
        repeat (20) cyc(0, 0);

`ifdef CLK_ALARM_EN
        chk("wrap_ovf_count", ovfs, 1);
        chk("wrap_coincident", coinc, 1);
        async_reset();
        repeat (4) cyc(1, 0);
        cyc(0, 1);
        cyc(1, 0);
        chk("alm_mode", bus.modeOut, 0);
        chk("alm_min_set", bus.almMinOut, 1);
        chk("alm_time0", {bus.hourOut, bus.minOut, bus.secOut}, 0);
        hits = 0; coinc = 0;
        for (int k = 0; k < 250; k++) begin
            cyc(0, 0);
            hits += bus.almHit;
            if (bus.almHit && bus.minOut == 1 && bus.secOut == 0) coinc++;
        end
        chk("alm_hits", hits, 1);
        chk("alm_coincident", coinc, 1);
        repeat (4) cyc(1, 0);
        cyc(0, 1);
        chk("alm_m_mode", bus.modeOut, 4);
        hits = 0;
        for (int k = 0; k < 250; k++) begin
            cyc(0, 0);
            hits += bus.almHit;
        end
        chk("alm_m_min", bus.minOut, 2);
        chk("alm_m_nohit", hits, 0);
        cyc(1, 0);
`endif

        // Random buttons with occasional async resets.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 999) == 0) async_reset();
            cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25);
        end
        cyc(0, 0);
        chk("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Synchronous timekeeping controller for the digital clock. It divides the system clock into a 1 Hz second tick and sequences the hh:mm:ss counters with in-cycle carry, replacing the ripple-carry counter chain. A two-button set-mode state machine lets the user adjust the hour and minute. Its outputs drive the 7-segment display decoders.

## Interface
- CLK_HZ, 50000000, system clock cycles per second; legal range ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- btnMode  in  1  one-cycle pulse, already debounced and synchronised; advances the set-mode FSM.
- btnInc  in  1  one-cycle pulse, already debounced and synchronised; increments the field selected in set mode.
- secOut  out  6  seconds, 0..59.
- minOut  out  6  minutes, 0..59.
- hourOut  out  5  hours, 0..23.
- modeOut  out  3  current FSM state encoding.
- tickSec  out  1  one-cycle pulse on each second advance.
- ovflwDay  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 wrap.
- almHourOut  out  5  alarm hour. Present only with ALARM_EN.
- almMinOut  out  6  alarm minute. Present only with ALARM_EN.
- almHit  out  1  one-cycle alarm pulse. Present only with ALARM_EN.

## Operation
**Reset (resetN = 0), immediate and asynchronous:**
- prescaler = 0; secOut, minOut, hourOut = 0.
- modeOut = RUN; tickSec = 0; ovflwDay = 0.
- almHourOut, almMinOut, almHit = 0.

**FSM states:** RUN = 0, SET_HOUR = 1, SET_MIN = 2, SET_ALM_H = 3, SET_ALM_M = 4.
- btnMode moves to the next state: RUN → SET_HOUR → SET_MIN → RUN.
- With ALARM_EN the cycle is RUN → SET_HOUR → SET_MIN → SET_ALM_H → SET_ALM_M → RUN.

**Prescaler:**
- Counts 0..CLK_HZ-1 in RUN, SET_ALM_H and SET_ALM_M, then wraps to 0.
- When the count is CLK_HZ-1, a second advance is scheduled for the next edge.

**Second advance:**
- secOut increments by 1.
- secOut 59 → 0 carries +1 into minOut.
- minOut 59 → 0 carries +1 into hourOut.
- hourOut 23 → 0 asserts ovflwDay.
- All carries resolve in the same edge; there is no ripple delay.

**SET_HOUR / SET_MIN:**
- Prescaler is held at 0; secOut is held.
- btnInc increments the selected field with wrap: hour 23 → 0, minute 59 → 0. No carry into any other field.
- On the btnMode that leaves SET_MIN (to RUN, or to SET_ALM_H with ALARM_EN): secOut and the prescaler clear to 0.

**Input rules:**
- btnInc in RUN is ignored.
- btnMode and btnInc in the same cycle: btnMode wins and btnInc is dropped.
- Counters never exceed their legal range. Out-of-range values cannot occur.

## Timing
- All outputs are registered.
- tickSec rises on the same edge that updates secOut.
- First tickSec comes exactly CLK_HZ cycles after reset release or after leaving SET_MIN; later ticks come every CLK_HZ cycles.
- ovflwDay is high for exactly the one cycle in which 00:00:00 first appears.
- A btnMode or btnInc pulse sampled on edge N is reflected in modeOut or the field at edge N.
- Reset asserted mid-count or mid-set: outputs go to their reset values with no clock needed.
- Counting resumes from 0 on the first edge after release.

## Configuration
- Macro: CLK_ALARM_EN.
- **Defined:**
  - States SET_ALM_H and SET_ALM_M exist.
  - btnInc there edits almHourOut and almMinOut, with the same wrap rules as the time fields.
  - Time keeps running in both alarm states.
  - almHit pulses for 1 cycle, in RUN only, on the second advance that makes hh:mm:ss equal almHour:almMin:00.
- **Undefined:**
  - SET_MIN → RUN directly; states 3 and 4 are unreachable.
  - The alarm ports and alarm registers are absent.

## Test plan
- **Async reset:** CLK_HZ=4, run 10 cycles, then drop resetN between edges → all outputs 0 and modeOut=0 before the next edge.
- **Free run:** CLK_HZ=4, release reset → tickSec every 4 cycles, first at cycle 4; after 60 ticks, secOut=0, minOut=1, hourOut=0.
- **Day wrap:**
  - Stimulus: btnMode, 23×btnInc, btnMode, 59×btnInc, btnMode.
  - Then: 60 ticks.
  - Required: 00:00:00 appears with ovflwDay=1 for exactly 1 cycle and tickSec=1 in that same cycle.
- **Set-mode wrap:** in SET_HOUR with hour=23, pulse btnInc → hourOut=0, minOut and secOut unchanged, no ovflwDay.
- **Collision:** in SET_HOUR with hour=5, btnMode and btnInc in the same cycle → modeOut=2, hourOut=5.
- **CLK_ALARM_EN:**
  - Stimulus: set alarm to 00:01; return to RUN with time at 00:00:00.
  - Required: almHit=1 for exactly 1 cycle, coincident with minOut becoming 1 and secOut=0.
  - Required: no almHit while in SET_ALM_M.
